// File: rtl/regfile_bist_pkg.sv
// Shared types, widths and the expected-pattern function for the register-file BIST.
package regfile_bist_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDone
  } state_e;

  // Register 0 reads back as zero when it is hardwired, whatever was written.
  function automatic logic [DATA_W-1:0] bist_expected(input logic [ADDR_W-1:0] idx,
                                                      input logic [DATA_W-1:0] seed,
                                                      input logic [DATA_W-1:0] stride,
                                                      input logic              zero_reg);
    if (zero_reg && (idx == '0)) begin
      return '0;
    end
    return seed + stride * {{(DATA_W - ADDR_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// Register-file port bundle: one write port and two combinational read ports.
interface regfile_bist_if;

  logic                                 reg_write;
  logic [regfile_bist_pkg::ADDR_W-1:0] write_register;
  logic [regfile_bist_pkg::DATA_W-1:0] write_data;
  logic [regfile_bist_pkg::ADDR_W-1:0] read_register_1;
  logic [regfile_bist_pkg::ADDR_W-1:0] read_register_2;
  logic [regfile_bist_pkg::DATA_W-1:0] read_data_1;
  logic [regfile_bist_pkg::DATA_W-1:0] read_data_2;

  modport master (
    output reg_write,
    output write_register,
    output write_data,
    output read_register_1,
    output read_register_2,
    input  read_data_1,
    input  read_data_2
  );

  modport slave (
    input  reg_write,
    input  write_register,
    input  write_data,
    input  read_register_1,
    input  read_register_2,
    output read_data_1,
    output read_data_2
  );

endinterface

// File: rtl/regfile_bist.sv
// Register-file BIST: writes SEED+STRIDE*i to every register, reads back two per cycle,
// and reports pass, lowest failing index and mismatch count.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter logic [DATA_W-1:0] SEED     = 32'd1,
  parameter logic [DATA_W-1:0] STRIDE   = 32'd3,
  parameter bit                ZERO_REG = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  regfile_bist_if.master       rf,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_W-1:0]    fail_index,
  output logic [5:0]           fail_count
);

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                reg_write_q;
  logic [ADDR_W-1:0]   wr_reg_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [ADDR_W-1:0]   rd1_q;
  logic [ADDR_W-1:0]   rd2_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [ADDR_W-1:0]   fail_index_q;
  logic [5:0]          fail_count_q;

  logic                mis1;
  logic                mis2;
  logic [5:0]          fail_count_d;
  logic [ADDR_W-1:0]   idx_inc;
  logic [3:0]          k_inc;

  assign idx_inc = idx_q + 5'd1;
  assign k_inc   = idx_q[3:0] + 4'd1;

  always_comb begin
    mis1         = rf.read_data_1 != bist_expected(rd1_q, SEED, STRIDE, ZERO_REG);
    mis2         = rf.read_data_2 != bist_expected(rd2_q, SEED, STRIDE, ZERO_REG);
    fail_count_d = fail_count_q + {5'd0, mis1} + {5'd0, mis2};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      reg_write_q  <= 1'b0;
      wr_reg_q     <= '0;
      wr_data_q    <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_index_q <= '0;
      fail_count_q <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StWrite;
            idx_q        <= '0;
            reg_write_q  <= 1'b1;
            wr_reg_q     <= '0;
            wr_data_q    <= bist_expected('0, SEED, STRIDE, 1'b0);
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_index_q <= '0;
            fail_count_q <= '0;
          end
        end
        StWrite: begin
          if (idx_q == 5'd31) begin
            state_q     <= StRead;
            idx_q       <= '0;
            reg_write_q <= 1'b0;
            wr_reg_q    <= '0;
            wr_data_q   <= '0;
            rd1_q       <= 5'd0;
            rd2_q       <= 5'd1;
          end else begin
            idx_q     <= idx_inc;
            wr_reg_q  <= idx_inc;
            wr_data_q <= bist_expected(idx_inc, SEED, STRIDE, 1'b0);
          end
        end
        StRead: begin
          fail_count_q <= fail_count_d;
          // Only the first failing cycle records an index; port 1 holds the lower address.
          if (fail_count_q == '0) begin
            if (mis1) begin
              fail_index_q <= rd1_q;
            end else if (mis2) begin
              fail_index_q <= rd2_q;
            end
          end
          if (idx_q[3:0] == 4'd15) begin
            state_q <= StDone;
            idx_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_count_d == '0);
          end else begin
            idx_q <= idx_inc;
            rd1_q <= {k_inc, 1'b0};
            rd2_q <= {k_inc, 1'b1};
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rf.reg_write       = reg_write_q;
  assign rf.write_register  = wr_reg_q;
  assign rf.write_data      = wr_data_q;
  assign rf.read_register_1 = rd1_q;
  assign rf.read_register_2 = rd2_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign fail_index         = fail_index_q;
  assign fail_count         = fail_count_q;

endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench: behavioural register file with injectable faults around regfile_bist.
module tb_regfile_bist;

  logic       clock;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_index;
  logic [5:0] fail_count;

  regfile_bist_if rf ();

  regfile_bist dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rf         (rf.master),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_index (fail_index),
    .fail_count (fail_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] regs [32];
  logic        stuck7;
  logic        corrupt;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          idle_writes;

  always @(posedge clock) begin
    if (rf.reg_write) regs[rf.write_register] <= rf.write_data;
  end

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : regs[a];
    if (stuck7 && a == 5'd7) v = 32'd0;
    if (corrupt && (a == 5'd5 || a == 5'd20)) v = v ^ 32'h0000_0100;
    return v;
  endfunction

  assign rf.read_data_1 = rd_model(rf.read_register_1);
  assign rf.read_data_2 = rd_model(rf.read_register_2);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".reg_write"}, {31'd0, rf.reg_write}, 32'd0);
    chk({tag, ".write_register"}, {27'd0, rf.write_register}, 32'd0);
    chk({tag, ".write_data"}, rf.write_data, 32'd0);
    chk({tag, ".read_register_1"}, {27'd0, rf.read_register_1}, 32'd0);
    chk({tag, ".read_register_2"}, {27'd0, rf.read_register_2}, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".pass"}, {31'd0, pass}, 32'd0);
    chk({tag, ".fail_index"}, {27'd0, fail_index}, 32'd0);
    chk({tag, ".fail_count"}, {26'd0, fail_count}, 32'd0);
    chk({tag, ".state"}, {30'd0, dut.state_q}, {30'd0, regfile_bist_pkg::StIdle});
  endtask

  // Start is sampled at edge T0; cycle n lies between edge T0+n-1 and edge T0+n.
  task automatic run_bist(input int pulse_cycle, input int reset_cycle,
                          output int done_at, output int busy_cycles);
    done_at     = -1;
    busy_cycles = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start       = 1'b0;
    busy_cycles = busy ? 1 : 0;
    for (int n = 1; n <= 70; n++) begin
      if (n == pulse_cycle) start = 1'b1;
      if (n == reset_cycle) begin
        @(negedge clock);
        chk("pre_reset.reg_write", {31'd0, rf.reg_write}, 32'd1);
        reset = 1'b1;
        #1;
        return;
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      if (busy) busy_cycles++;
      if (done) begin
        done_at = n + 1;
        break;
      end
    end
  endtask

  int done_at;
  int busy_cycles;

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    stuck7  = 1'b0;
    corrupt = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'hdead_beef;
    #12;
    chk_quiet("reset");
    @(negedge clock);
    reset       = 1'b0;
    idle_writes = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      if (rf.reg_write) idle_writes++;
    end
    chk_quiet("idle");
    chk("idle.write_pulses", idle_writes, 32'd0);

    // Healthy register file.
    run_bist(0, 0, done_at, busy_cycles);
    chk("healthy.done_at", done_at, 32'd49);
    chk("healthy.busy_cycles", busy_cycles, 32'd48);
    chk("healthy.r5", regs[5], 32'd16);
    chk("healthy.r31", regs[31], 32'd94);
    chk("healthy.r0_written", regs[0], 32'd1);
    chk("healthy.pass", {31'd0, pass}, 32'd1);
    chk("healthy.fail_count", {26'd0, fail_count}, 32'd0);
    chk("healthy.fail_index", {27'd0, fail_index}, 32'd0);
    chk("healthy.reg_write", {31'd0, rf.reg_write}, 32'd0);
    chk("healthy.read_register_2", {27'd0, rf.read_register_2}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("healthy.done_hold", {31'd0, done}, 32'd1);
    chk("healthy.pass_hold", {31'd0, pass}, 32'd1);

    // Register 7 stuck at zero; restart directly from DONE.
    stuck7 = 1'b1;
    run_bist(0, 0, done_at, busy_cycles);
    chk("stuck7.done_at", done_at, 32'd49);
    chk("stuck7.pass", {31'd0, pass}, 32'd0);
    chk("stuck7.fail_index", {27'd0, fail_index}, 32'd7);
    chk("stuck7.fail_count", {26'd0, fail_count}, 32'd1);
    stuck7 = 1'b0;

    // r5 fails on port 2 before r20 is read.
    corrupt = 1'b1;
    run_bist(0, 0, done_at, busy_cycles);
    chk("corrupt.done_at", done_at, 32'd49);
    chk("corrupt.pass", {31'd0, pass}, 32'd0);
    chk("corrupt.fail_index", {27'd0, fail_index}, 32'd5);
    chk("corrupt.fail_count", {26'd0, fail_count}, 32'd2);
    corrupt = 1'b0;

    // Start pulse during WRITE is ignored.
    run_bist(10, 0, done_at, busy_cycles);
    chk("midstart.done_at", done_at, 32'd49);
    chk("midstart.busy_cycles", busy_cycles, 32'd48);
    chk("midstart.pass", {31'd0, pass}, 32'd1);
    chk("midstart.fail_count", {26'd0, fail_count}, 32'd0);

    // Asynchronous reset in the middle of the write phase.
    run_bist(0, 12, done_at, busy_cycles);
    chk_quiet("async_reset");
    @(negedge clock);
    reset = 1'b0;
    run_bist(0, 0, done_at, busy_cycles);
    chk("after_reset.done_at", done_at, 32'd49);
    chk("after_reset.pass", {31'd0, pass}, 32'd1);
    chk("after_reset.fail_count", {26'd0, fail_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test sequencer that drives the write and both read ports of the datapath's 32×32 register file (`Registers`). After a start pulse it writes a deterministic arithmetic pattern into every register, reads all registers back two per cycle, and reports pass/fail, the lowest failing register index, and the mismatch count. It sits beside `Registers` in the datapath and is muxed onto the register-file ports only while `busy` is high; the mux is outside this block.

## Interface
Parameters:
- `SEED`, 32'd1: pattern value for register i is `SEED + STRIDE*i`, modulo 2^32.
- `STRIDE`, 32'd3: pattern increment per register index.
- `ZERO_REG`, 1: when 1, register 0 is hardwired; its expected read value is 0 regardless of pattern.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a test.
- `reg_write` out 1: write enable to `Registers`.
- `write_register` out 5: write address.
- `write_data` out 32: write data.
- `read_register_1` out 5: read port 1 address.
- `read_register_2` out 5: read port 2 address.
- `read_data_1` in 32: read port 1 data.
- `read_data_2` in 32: read port 2 data.
- `busy` out 1: high in WRITE and READ.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`; 1 iff zero mismatches.
- `fail_index` out 5: lowest mismatching register index; 0 if none.
- `fail_count` out 6: number of mismatching registers, 0..32.

## Operation
- `Registers` contract: writes commit on the rising edge when `reg_write`=1; reads are combinational from the address.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE: `start`=1 moves to WRITE. Index clears to 0, and `fail_count`, `fail_index` and `pass` clear.
  - WRITE: `reg_write`=1, `write_register`=idx, `write_data`=`SEED+STRIDE*idx`. The index increments each cycle. After idx=31, move to READ with k=0.
  - READ: `reg_write`=0, `read_register_1`=2k, `read_register_2`=2k+1. Both returned words are compared in the same cycle against expected values (register 0 expects 0 when `ZERO_REG`=1). Each mismatch increments `fail_count` (by up to 2 per cycle). `fail_index` captures the lowest failing index on the first mismatch only; port 1 wins a same-cycle tie. After k=15, move to DONE.
  - DONE: `pass` = (`fail_count`==0). All outputs hold. `start`=1 restarts the test exactly as from IDLE.
- `start` is ignored in WRITE and READ.
- All address and data outputs are registered (flop-driven). `write_data` wraps modulo 2^32.
- Outside WRITE: `reg_write`=0, and `write_register`/`write_data` are 0.
- Outside READ: both read addresses are 0.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- An asynchronous reset mid-operation returns to IDLE immediately. `reg_write` drops with no clock edge required; a partial write pattern is left in the register file.
- `start` is sampled at edge T0. Write cycles are T0+1 … T0+32. Read cycles are T0+33 … T0+48. `done` goes high at T0+49 and stays high until the next accepted `start` or reset.
- `busy` is high for exactly 48 cycles per test.
- `fail_count` and `fail_index` reach their final values on the edge that enters DONE.

## Structure
- Package `regfile_bist_pkg`:
  - state enum (IDLE/WRITE/READ/DONE)
  - `NUM_REGS`=32, `ADDR_W`=5, `DATA_W`=32
  - function `bist_expected(idx, seed, stride, zero_reg)`
- One module. A 5-bit index counter is shared by both phases: WRITE uses idx, READ uses k = idx[3:0]. No sub-module is needed.

## Test plan
- Reset, then idle for 5 cycles: all outputs 0 and no write pulses.
- Start with a healthy `Registers` using defaults:
  - r5 is written with 16, r31 with 94.
  - `done` rises at T0+49 with `pass`=1, `fail_count`=0.
  - r0 reads as 0 and is not flagged.
- Model register 7 stuck at 0: `pass`=0, `fail_index`=7, `fail_count`=1.
- Corrupt r20 and r5 (r5 fails on port 2 in the same READ phase): `fail_index`=5, `fail_count`=2.
- Pulse `start` at T0+10 during WRITE: ignored, and `done` still rises at T0+49.
- Assert `reset` asynchronously mid-clock at T0+12: `reg_write` falls immediately, and all outputs read 0 with state IDLE. A fresh `start` then completes in 49 cycles.
